tm1638_display_ctrl: RTL and testbench
======================================

TM1638_DISPLAY_CTRL -- requirements
Module: tm1638_display_ctrl

Interface
REQ-001 SHALL have parameter INIT_REFRESH, default 1: when 1, one refresh runs automatically after reset release.
REQ-002 SHALL have port i_Clk, input, 1, sole clock; all state changes on posedge.
REQ-003 SHALL have port i_Rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_Update, input, 1, single-cycle refresh request.
REQ-005 SHALL have port i_Segments, input, 64, digit k segment byte at [8k+7:8k], k=0..7.
REQ-006 SHALL have port i_Leds, input, 8, LED k on when bit k=1.
REQ-007 SHALL have port i_Brightness, input, 3, display pulse width 0..7.
REQ-008 SHALL have port i_Display_On, input, 1, display enable.
REQ-009 SHALL have port i_SPI_Busy, input, 1, busy flag from downstream SPI transmitter.
REQ-010 SHALL have port o_Data_Ready, output, 1, transaction strobe to the SPI transmitter.
REQ-011 SHALL have port o_Data, output, 17, transaction word: [16] has-data flag, [15:8] data, [7:0] command.
REQ-012 SHALL have port o_Busy, output, 1, high while a refresh is in progress.
REQ-013 SHALL have port o_Done, output, 1, one-cycle pulse when a refresh completes.

Function
REQ-014 On i_Update=1 in IDLE, SHALL snapshot i_Segments, i_Leds, i_Brightness and i_Display_On, then start a refresh; later input changes SHALL NOT affect the refresh in progress.
REQ-015 A refresh SHALL issue 18 transactions, with index n=0..17, in strict order.
- n=0: {1'b0, 8'h00, 8'h44}, fixed-address write mode.
- n=1..16, with a=n-1: {1'b1, D, 8'hC0|a}. D=segment byte of digit a/2 for even a; D={7'b0, led[(a-1)/2]} for odd a.
- n=17: {1'b0, 8'h00, 8'h80|(on<<3)|brightness}.
REQ-016 States SHALL be IDLE, SETUP, SEND, WAIT_ACK, WAIT_DONE.
- IDLE->SETUP on a request; the snapshot is taken and n=0.
- SETUP->SEND when i_SPI_Busy=0; o_Data is valid and stable from SETUP through WAIT_DONE.
- SEND lasts exactly one cycle with o_Data_Ready=1, then ->WAIT_ACK.
- WAIT_ACK->WAIT_DONE when i_SPI_Busy=1, sampled no earlier than the cycle after SEND.
- WAIT_DONE->SETUP with n+1 when i_SPI_Busy=0 and n<17.
- WAIT_DONE->IDLE when i_SPI_Busy=0 and n=17; o_Done=1 for that one cycle.
REQ-017 o_Data_Ready SHALL be 1 only in SEND and SHALL never be high on two consecutive cycles.
REQ-018 o_Busy SHALL be 1 in every state except IDLE.
REQ-019 An i_Update during a refresh SHALL set a pending flag; multiple requests SHALL collapse into one.
REQ-020 On return to IDLE with the pending flag set, the block SHALL clear the flag and start a new refresh on the next cycle, with a fresh snapshot.
REQ-021 An i_Update in the same cycle as the o_Done pulse SHALL be treated as pending; it SHALL NOT be lost.
REQ-022 If i_SPI_Busy is already 1 in SETUP, the block SHALL wait; SEND SHALL never be entered while i_SPI_Busy=1.
REQ-023 The transaction index SHALL be 5 bits and SHALL NOT wrap past 17.

Reset
REQ-024 While i_Rst_n=0, the block SHALL hold: state IDLE, o_Data_Ready=0, o_Data=0, o_Busy=0, o_Done=0, pending flag=0, index=0, snapshot=0.
REQ-025 A reset asserted mid-refresh SHALL abort it immediately; no further transactions SHALL be issued.
REQ-026 With INIT_REFRESH=1, the pending flag SHALL be set on the first clock after reset release, giving a refresh with the inputs sampled at that time.

Verification
REQ-027 Basic refresh: INIT_REFRESH=0; SPI model busy 5 cycles per word; i_Update with segments=64'h0706050403020100, leds=8'hA5, brightness=3, on=1. Required: exactly 18 words in order, starting 17'h00044 and 17'h100C0. Word for address 1 is {1'b1, 8'h01, 8'hC1}; word for address 2 is {1'b1, 8'h01, 8'hC2}. Last word is 17'h0008B; o_Done pulses once.
REQ-028 Handshake: SPI model raises busy the cycle after the strobe. Required: o_Data_Ready is 1 for exactly 1 cycle per word, never while i_SPI_Busy=1, and o_Data is unchanged while busy.
REQ-029 Coalescing: 3 i_Update pulses during a refresh, with the inputs changed before the last one. Required: exactly one follow-up refresh carrying the latest values; 36 words in total.
REQ-030 Done collision: i_Update coincides with the o_Done cycle. Required: a second refresh starts and o_Busy drops for at most 1 cycle.
REQ-031 Reset abort: i_Rst_n=0 after word 5. Required: all outputs 0 asynchronously and no strobe while in reset. With INIT_REFRESH=1, a full 18-word refresh follows reset release.
REQ-032 Stalled SPI: i_SPI_Busy held 1 before the first word. Required: the block stays in SETUP with o_Data_Ready=0 until busy falls, then sends.

Source files
------------

// File: rtl/tm1638_display_ctrl.sv
// ============================================================================
// tm1638_display_ctrl: sequences the 18-word TM1638 refresh towards an SPI TX
// Revision: 1.0
// ============================================================================
`default_nettype none

module tm1638_display_ctrl #(
  parameter int INIT_REFRESH = 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Update,
  input  logic [63:0] i_Segments,
  input  logic [7:0]  i_Leds,
  input  logic [2:0]  i_Brightness,
  input  logic        i_Display_On,
  input  logic        i_SPI_Busy,
  output logic        o_Data_Ready,
  output logic [16:0] o_Data,
  output logic        o_Busy,
  output logic        o_Done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd17;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic        started_q;
  logic        load;

  logic [63:0] seg_q;
  logic [7:0]  led_q;
  logic [2:0]  bright_q;
  logic        on_q;

  logic [3:0]  w_addr;
  logic [7:0]  w_seg_byte;
  logic        w_led_bit;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      pending_q <= 1'b0;
      started_q <= 1'b0;
      seg_q     <= 64'd0;
      led_q     <= 8'd0;
      bright_q  <= 3'd0;
      on_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      started_q <= 1'b1;
      if (load) begin
        seg_q    <= i_Segments;
        led_q    <= i_Leds;
        bright_q <= i_Brightness;
        on_q     <= i_Display_On;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    load      = 1'b0;
    o_Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q || i_Update) begin
          state_d   = SETUP;
          idx_d     = 5'd0;
          pending_d = 1'b0;
          load      = 1'b1;
        end
      end
      SETUP: begin
        if (!i_SPI_Busy) state_d = SEND;
      end
      SEND: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_SPI_Busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!i_SPI_Busy) begin
          if (idx_q >= LAST_IDX) begin
            state_d = IDLE;
            o_Done  = 1'b1;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Requests arriving mid-refresh (including the done cycle) collapse into one.
    if (state_q != IDLE && i_Update) pending_d = 1'b1;
    if (INIT_REFRESH != 0 && !started_q && !load) pending_d = 1'b1;
  end

  // Words 1..16 alternate digit segment byte / LED bit, address = index - 1.
  assign w_addr     = idx_q[3:0] - 4'd1;
  assign w_seg_byte = seg_q[{w_addr[3:1], 3'b000} +: 8];
  assign w_led_bit  = led_q[w_addr[3:1]];

  always_comb begin
    o_Data = 17'd0;
    if (state_q != IDLE) begin
      if (idx_q == 5'd0) begin
        o_Data = {1'b0, 8'h00, 8'h44};
      end else if (idx_q >= LAST_IDX) begin
        o_Data = {1'b0, 8'h00, 4'h8, on_q, bright_q};
      end else if (w_addr[0]) begin
        o_Data = {1'b1, 7'd0, w_led_bit, 4'hC, w_addr};
      end else begin
        o_Data = {1'b1, w_seg_byte, 4'hC, w_addr};
      end
    end
  end

  assign o_Data_Ready = (state_q == SEND);
  assign o_Busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tm1638_display_ctrl.sv
// ============================================================================
// tb_tm1638_display_ctrl: scoreboard bench with a behavioural SPI responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tm1638_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic        upd;
  logic [63:0] seg;
  logic [7:0]  leds;
  logic [2:0]  br;
  logic        on;
  logic        model_busy;
  logic        stall;
  logic        spi_busy;
  logic        o_Data_Ready;
  logic [16:0] o_Data;
  logic        o_Busy;
  logic        o_Done;

  assign spi_busy = model_busy | stall;

  tm1638_display_ctrl #(.INIT_REFRESH(1)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Update     (upd),
    .i_Segments   (seg),
    .i_Leds       (leds),
    .i_Brightness (br),
    .i_Display_On (on),
    .i_SPI_Busy   (spi_busy),
    .o_Data_Ready (o_Data_Ready),
    .o_Data       (o_Data),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          vectors;
  int          miscompares;
  int          strobes;
  int          dones;
  int          busy_min;
  int          busy_max;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the word sequence a TM1638 refresh must produce for given inputs.
  function automatic logic [16:0] ref_word(input int n, input logic [63:0] s, input logic [7:0] l,
                                           input logic [2:0] b, input logic d_on);
    int a;
    logic [7:0] d;
    if (n == 0) return {1'b0, 8'h00, 8'h44};
    if (n == 17) return {1'b0, 8'h00, 8'h80 | (d_on ? 8'h08 : 8'h00) | {5'd0, b}};
    a = n - 1;
    if (a % 2 == 0) d = s[8*(a/2) +: 8];
    else            d = {7'd0, l[(a-1)/2]};
    return {1'b1, d, 8'hC0 + 8'(a)};
  endfunction

  task automatic push_refresh();
    for (int n = 0; n < 18; n++) exp_q.push_back(ref_word(n, seg, leds, br, on));
  endtask

  task automatic randomize_inputs();
    seg  = {$urandom, $urandom};
    leds = 8'($urandom);
    br   = 3'($urandom);
    on   = 1'($urandom);
  endtask

  task automatic pulse();
    @(negedge clk); #2 upd = 1'b1;
    @(negedge clk); #2 upd = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !o_Busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("refresh_completes", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // SPI responder: busy rises the cycle after each strobe, for a random length.
  initial begin
    logic        arm;
    logic        prev_rdy;
    logic [16:0] held;
    int          cnt;
    model_busy = 1'b0;
    arm = 1'b0; prev_rdy = 1'b0; held = '0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_busy = 1'b0; arm = 1'b0; prev_rdy = 1'b0; cnt = 0;
        continue;
      end
      if (o_Data_Ready) begin
        check("strobe_while_busy", 64'(spi_busy), 64'd0);
        check("strobe_back_to_back", 64'(prev_rdy), 64'd0);
        held = o_Data;
      end
      if (model_busy) begin
        check("data_stable_busy", 64'(o_Data), 64'(held));
        cnt--;
        if (cnt <= 0) model_busy = 1'b0;
      end else if (arm) begin
        model_busy = 1'b1;
        cnt = $urandom_range(busy_max, busy_min);
        arm = 1'b0;
      end
      if (o_Data_Ready) arm = 1'b1;
      prev_rdy = o_Data_Ready;
    end
  end

  // Monitor: pops the scoreboard on every strobe.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        check("reset_outputs", 64'({o_Data_Ready, o_Data, o_Busy, o_Done}), 64'd0);
      end else begin
        if (o_Data_Ready) begin
          strobes++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %h expected none at %0t", o_Data, $time);
          end else begin
            check("word", 64'(o_Data), 64'(exp_q.pop_front()));
          end
        end
        if (o_Done) dones++;
      end
    end
  end

  initial begin
    int d0;
    int s0;
    int seen;
    int low;
    logic got;
    vectors = 0; miscompares = 0; strobes = 0; dones = 0;
    busy_min = 1; busy_max = 6;
    rst_n = 1'b0; upd = 1'b0; stall = 1'b0;
    randomize_inputs();
    repeat (3) @(negedge clk);

    // Power-up refresh with the inputs present at reset release.
    randomize_inputs();
    push_refresh();
    #2 rst_n = 1'b1;
    wait_idle();
    check("init_done_count", 64'(dones), 64'd1);

    // Basic refresh, fixed 5-cycle busy.
    busy_min = 5; busy_max = 5;
    seg = 64'h0706050403020100; leds = 8'hA5; br = 3'd3; on = 1'b1;
    d0 = dones;
    push_refresh();
    pulse();
    wait_idle();
    check("basic_done_once", 64'(dones - d0), 64'd1);

    // Random refreshes with random busy lengths.
    busy_min = 1; busy_max = 6;
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      d0 = dones;
      push_refresh();
      pulse();
      wait_idle();
      check("rand_done_once", 64'(dones - d0), 64'd1);
    end

    // Coalescing: three requests mid-refresh give one follow-up with latest values.
    randomize_inputs();
    d0 = dones;
    push_refresh();
    pulse();
    s0 = strobes;
    for (int i = 0; i < 500 && strobes < s0 + 3; i++) @(negedge clk);
    randomize_inputs();
    pulse();
    pulse();
    randomize_inputs();
    pulse();
    push_refresh();
    wait_idle();
    check("coalesce_done_twice", 64'(dones - d0), 64'd2);

    // Request coinciding with the done pulse.
    randomize_inputs();
    d0 = dones;
    push_refresh();
    pulse();
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (o_Done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    upd = 1'b1;
    push_refresh();
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      upd = 1'b0;
      if (o_Busy) break;
      low++;
    end
    check("busy_gap_le1", 64'(low <= 1), 64'd1);
    wait_idle();
    check("collision_done_twice", 64'(dones - d0), 64'd2);

    // Stalled SPI: stays in SETUP presenting the first word.
    randomize_inputs();
    @(negedge clk); #2 stall = 1'b1;
    push_refresh();
    pulse();
    s0 = strobes;
    repeat (20) @(negedge clk);
    #1;
    check("stall_no_strobe", 64'(strobes - s0), 64'd0);
    check("stall_busy", 64'(o_Busy), 64'd1);
    check("stall_data", 64'(o_Data), 64'(exp_q[0]));
    @(negedge clk); #2 stall = 1'b0;
    wait_idle();

    // Reset abort after the fifth word, then the power-up refresh again.
    busy_min = 2; busy_max = 4;
    randomize_inputs();
    push_refresh();
    pulse();
    seen = 0;
    for (int i = 0; i < 2000 && seen < 5; i++) begin
      @(negedge clk); #1;
      if (o_Data_Ready) seen++;
    end
    check("abort_reached_word5", 64'(seen), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'({o_Data_Ready, o_Data, o_Busy, o_Done}), 64'd0);
    exp_q.delete();
    randomize_inputs();
    push_refresh();
    d0 = dones;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_idle();
    check("post_reset_done_once", 64'(dones - d0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
